// File: rtl/usb_rx_pkg.sv
// rtl/usb_rx_pkg.sv - shared types and constants for the USB receive controller
// Contents: rx_state_t (controller FSM states), SYNC_BYTE_DEF (LSB-first sync pattern).
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC_RCV,
    SYNC_CHK,
    DATA_RCV,
    STORE,
    EOP_END,
    ERR_WAIT,
    ERR_EOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;

endpackage

// File: rtl/usb_rx_bit_cnt.sv
// rtl/usb_rx_bit_cnt.sv - bit counter with clear/enable and byte-complete flag
// Ports: clk, n_rst (async active-low), clear, enable -> count (bits so far),
//        rollover (this enable completes a byte, i.e. next count == BYTE_BITS).
module usb_rx_bit_cnt #(
  parameter int BYTE_BITS = 8,
  localparam int CW = $clog2(BYTE_BITS + 1)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          rollover
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flag looks at the next value so the FSM can leave on the very shift
  // that completes the byte.
  assign rollover = (cnt_d == CW'(BYTE_BITS));
  assign count    = cnt_q;

endmodule

// File: rtl/usb_rx_ctrl.sv
// rtl/usb_rx_ctrl.sv - USB receive byte assembler and control unit feeding rx_fifo
// Ports: clk, n_rst (async active-low); d_edge, shift_enable, d_orig, eop from the
//        bit decoder; full from rx_fifo; w_enable/w_data to rx_fifo; rcving, r_error status.
// Optional feature: define RX_OVERRUN_CHECK_EN to suppress writes into a full rx_fifo
//        and flag an error; otherwise full is ignored.
module usb_rx_ctrl
  import usb_rx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         BYTE_BITS = 8,
  localparam int        CW        = $clog2(BYTE_BITS + 1)
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       shift_enable,
  input  logic       d_orig,
  input  logic       eop,
  input  logic       full,
  output logic       w_enable,
  output logic [7:0] w_data,
  output logic       rcving,
  output logic       r_error
);

  rx_state_t     state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    w_data_q, w_data_d;
  logic          r_error_q, r_error_d;
  logic          rcving_q;
  logic          in_rx;
  logic          shift_en;
  logic          cnt_clear;
  logic [CW-1:0] cnt;
  logic          rollover;

  usb_rx_bit_cnt #(.BYTE_BITS(BYTE_BITS)) u_bit_cnt (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (cnt_clear),
    .enable   (shift_en),
    .count    (cnt),
    .rollover (rollover)
  );

  assign in_rx     = (state_q == SYNC_RCV) || (state_q == DATA_RCV);
  assign shift_en  = in_rx && shift_enable && !eop;
  // Counter only runs while bits are being assembled; every other state
  // holds it at zero, which covers the IDLE, SYNC_CHK and STORE clears.
  assign cnt_clear = !in_rx;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    w_data_d  = w_data_q;
    r_error_d = r_error_q;

    if (shift_en) begin
      sr_d = {d_orig, sr_q[7:1]};
    end

    case (state_q)
      IDLE: begin
        if (d_edge) begin
          state_d   = SYNC_RCV;
          r_error_d = 1'b0;
        end
      end
      SYNC_RCV: begin
        if (shift_enable && eop) begin
          state_d   = ERR_EOP;
          r_error_d = 1'b1;
        end else if (rollover) begin
          state_d = SYNC_CHK;
        end
      end
      SYNC_CHK: begin
        if (sr_q == SYNC_BYTE) begin
          state_d = DATA_RCV;
        end else begin
          state_d   = ERR_WAIT;
          r_error_d = 1'b1;
        end
      end
      DATA_RCV: begin
        if (shift_enable && eop) begin
          // EOP on a byte boundary is a clean end; mid-byte drops the fragment.
          if (cnt == '0) begin
            state_d = EOP_END;
          end else begin
            state_d   = ERR_EOP;
            r_error_d = 1'b1;
          end
        end else if (rollover) begin
          state_d  = STORE;
          w_data_d = sr_d;
        end
      end
      STORE: begin
        state_d = DATA_RCV;
`ifdef RX_OVERRUN_CHECK_EN
        if (full) begin
          state_d   = ERR_WAIT;
          r_error_d = 1'b1;
        end
`endif
      end
      EOP_END: begin
        if (d_edge) state_d = IDLE;
      end
      ERR_WAIT: begin
        if (shift_enable && eop) state_d = ERR_EOP;
      end
      ERR_EOP: begin
        if (d_edge) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      sr_q      <= 8'h00;
      w_data_q  <= 8'h00;
      r_error_q <= 1'b0;
      rcving_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      w_data_q  <= w_data_d;
      r_error_q <= r_error_d;
      rcving_q  <= (state_d != IDLE);
    end
  end

`ifdef RX_OVERRUN_CHECK_EN
  assign w_enable = (state_q == STORE) && !full;
`else
  logic unused_full;
  assign unused_full = full;
  assign w_enable    = (state_q == STORE);
`endif

  assign w_data  = w_data_q;
  assign rcving  = rcving_q;
  assign r_error = r_error_q;

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// tb/tb_usb_rx_ctrl.sv - self-checking bench for usb_rx_ctrl
module tb_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_edge = 1'b0;
  logic       shift_enable = 1'b0;
  logic       d_orig = 1'b0;
  logic       eop = 1'b0;
  logic       full = 1'b0;
  logic       w_enable;
  logic [7:0] w_data;
  logic       rcving;
  logic       r_error;

  usb_rx_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_edge       (d_edge),
    .shift_enable (shift_enable),
    .d_orig       (d_orig),
    .eop          (eop),
    .full         (full),
    .w_enable     (w_enable),
    .w_data       (w_data),
    .rcving       (rcving),
    .r_error      (r_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        wq[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_wr = 0;
  logic [7:0] last_wr = 8'h00;
  logic       prev_we = 1'b0;
  logic       exp_rcv = 1'b0;
  logic       prev_bit = 1'b0;
  logic [7:0] pay [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every-cycle compare against the expected write list and receive window.
  always @(negedge clk) begin
    if (n_rst) begin
      n_chk++;
      if (rcving !== exp_rcv) begin
        n_fail++;
        $display("FAIL rcving_cyc%0d: got %0b expected %0b", cyc, rcving, exp_rcv);
      end
      if (w_enable === 1'b1) begin
        n_chk++;
        n_wr++;
        last_wr = w_data;
        if (prev_we) begin
          n_fail++;
          $display("FAIL w_enable_width: got 2-cycle pulse expected 1 cycle");
        end
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got data %0h expected no write", w_data);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if (e.data !== w_data || e.cyc != cyc) begin
            n_fail++;
            $display("FAIL write: got %0h at cyc %0d expected %0h at cyc %0d",
                     w_data, cyc, e.data, e.cyc);
          end
        end
      end else if (wq.size() > 0 && cyc > wq[0].cyc) begin
        n_chk++;
        n_fail++;
        $display("FAIL missed_write: got none expected %0h at cyc %0d", wq[0].data, wq[0].cyc);
        void'(wq.pop_front());
      end
      prev_we = (w_enable === 1'b1);
    end else begin
      prev_we = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit period: strobe cycle, then two quiet cycles. When do_push is set
  // this is the last bit of a byte that must reach the FIFO on the next cycle.
  task automatic send_bit(input logic b, input logic e, input bit do_push, input logic [7:0] data);
    shift_enable = 1'b1;
    d_orig       = b;
    eop          = e;
    d_edge       = (b != prev_bit) && !e;
    tick();
    if (do_push) begin
      wr_t w;
      w.data = data;
      w.cyc  = cyc;
      wq.push_back(w);
    end
    shift_enable = 1'b0;
    eop          = 1'b0;
    d_edge       = 1'b0;
    prev_bit     = b;
    tick();
    tick();
  endtask

  task automatic start_packet(input logic [7:0] sync_b);
    d_edge = 1'b1;
    tick();
    d_edge  = 1'b0;
    exp_rcv = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send_bit(sync_b[i], 1'b0, 1'b0, 8'h00);
  endtask

  task automatic packet(input logic [7:0] sync_b, input int nbytes, input int extra, input logic full_v);
    bit   ovr;
    bit   dropping;
    logic exp_err;
    ovr = 1'b0;
`ifdef RX_OVERRUN_CHECK_EN
    ovr = full_v;
`endif
    full     = full_v;
    dropping = (sync_b != 8'h80);
    exp_err  = dropping || (extra != 0) || (ovr && nbytes > 0);
    start_packet(sync_b);
    chk("r_error_after_sync", r_error, {31'd0, dropping});
    for (int k = 0; k < nbytes; k++) begin
      for (int i = 0; i < 8; i++)
        send_bit(pay[k][i], 1'b0, !dropping && !ovr && i == 7, pay[k]);
      if (ovr) dropping = 1'b1;
    end
    for (int x = 0; x < extra; x++) send_bit(x[0], 1'b0, 1'b0, 8'h00);
    send_bit(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rcving_after_eop", rcving, 1);
    chk("r_error_after_eop", r_error, {31'd0, exp_err});
    d_edge = 1'b1;
    tick();
    d_edge  = 1'b0;
    exp_rcv = 1'b0;
    tick();
    chk("rcving_idle", rcving, 0);
    chk("r_error_idle", r_error, {31'd0, exp_err});
    chk("writes_pending", wq.size(), 0);
    full = 1'b0;
  endtask

  int wr0;

  initial begin
    repeat (3) tick();
    chk("reset_w_enable", w_enable, 0);
    chk("reset_w_data", w_data, 0);
    chk("reset_rcving", rcving, 0);
    chk("reset_r_error", r_error, 0);
    n_rst = 1'b1;
    repeat (2) tick();

    // Clean single byte.
    wr0 = n_wr;
    pay[0] = 8'hA5;
    packet(8'h80, 1, 0, 1'b0);
    chk("t1_count", n_wr - wr0, 1);
    chk("t1_data", last_wr, 8'hA5);

    // Bad sync: no writes, error held through IDLE.
    wr0 = n_wr;
    packet(8'h81, 0, 0, 1'b0);
    chk("t2_count", n_wr - wr0, 0);
    repeat (3) tick();
    chk("t2_r_error_held", r_error, 1);

    // Three bytes in order; also clears the previous error.
    wr0 = n_wr;
    pay[0] = 8'h00;
    pay[1] = 8'hFF;
    pay[2] = 8'h0F;
    packet(8'h80, 3, 0, 1'b0);
    chk("t4_count", n_wr - wr0, 3);
    chk("t4_last", last_wr, 8'h0F);

    // One byte then a partial byte before EOP.
    wr0 = n_wr;
    pay[0] = 8'h3C;
    packet(8'h80, 1, 3, 1'b0);
    chk("t3_count", n_wr - wr0, 1);
    chk("t3_data", last_wr, 8'h3C);

    // Empty packet.
    packet(8'h80, 0, 0, 1'b0);

    // FIFO full during STORE.
    wr0 = n_wr;
    pay[0] = 8'h5A;
    pay[1] = 8'h96;
    packet(8'h80, 2, 0, 1'b1);
`ifdef RX_OVERRUN_CHECK_EN
    chk("t5_count", n_wr - wr0, 0);
`else
    chk("t5_count", n_wr - wr0, 2);
    chk("t5_data", last_wr, 8'h96);
`endif

    // Reset in the middle of a data byte.
    start_packet(8'h80);
    for (int i = 0; i < 8; i++) send_bit(pay[2][i] ^ 1'b1, 1'b0, i == 7, 8'hF0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0, 8'h00);
    chk("t6_w_data_before", w_data, 8'hF0);
    #2;
    n_rst   = 1'b0;
    exp_rcv = 1'b0;
    #1;
    chk("t6_rst_w_enable", w_enable, 0);
    chk("t6_rst_w_data", w_data, 0);
    chk("t6_rst_rcving", rcving, 0);
    chk("t6_rst_r_error", r_error, 0);
    tick();
    n_rst    = 1'b1;
    prev_bit = 1'b0;
    tick();
    wr0 = n_wr;
    pay[0] = 8'hA5;
    packet(8'h80, 1, 0, 1'b0);
    chk("t6_count", n_wr - wr0, 1);
    chk("t6_data", last_wr, 8'hA5);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
